// File: rtl/fp_pkg.sv
// Shared floating-point definitions: exception flag layout and IEEE-754 single special values.
package fp_pkg;

    localparam int FLAG_W       = 4;
    localparam int FLAG_INEXACT = 0;
    localparam int FLAG_UN      = 1;
    localparam int FLAG_OV      = 2;
    localparam int FLAG_INV     = 3;

    localparam logic [31:0] FP_NANQ  = 32'h7FC0_0000;
    localparam logic [31:0] FP_INFP  = 32'h7F80_0000;
    localparam logic [31:0] FP_INFN  = 32'hFF80_0000;
    localparam logic [31:0] FP_ZEROP = 32'h0000_0000;
    localparam logic [31:0] FP_ZERON = 32'h8000_0000;
    localparam logic [31:0] FP_ONEP  = 32'h3F80_0000;

endpackage

// File: rtl/fp_result_collector_if.sv
// Result handshake bundle between fp_mul output stage, collector and downstream consumer.
interface fp_result_collector_if #(parameter int W = 32);
    import fp_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_data;
    logic              in_ov;
    logic              in_un;
    logic              in_inv;
    logic              in_inexact;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data;
    logic [FLAG_W-1:0] out_flags;

    // Producer of results and consumer of the head entry, seen from outside the collector.
    modport master (
        output in_valid, in_data, in_ov, in_un, in_inv, in_inexact, out_ready,
        input  in_ready, out_valid, out_data, out_flags
    );

    modport slave (
        input  in_valid, in_data, in_ov, in_un, in_inv, in_inexact, out_ready,
        output in_ready, out_valid, out_data, out_flags
    );

endinterface

// File: rtl/fp_sync_fifo.sv
// Generic synchronous FIFO with head read straight from the storage registers; push visible next cycle.
// Pushes are refused while full, pops ignored while empty; full/empty depend on registered count only.
module fp_sync_fifo #(
    parameter int DW    = 36,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fp_result_collector.sv
// Buffers fp_mul results+flags in a FIFO for a stalling consumer; 1-cycle push-to-head latency, in_ready = !full.
// FP_STICKY_FLAGS_EN adds sticky exception accumulation, flags_clr and the drop indicator.
module fp_result_collector
    import fp_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    fp_result_collector_if.slave  bus,
    output logic [AW:0]           count,
    input  logic                  flags_clr,
    output logic [FLAG_W-1:0]     sticky_flags,
    output logic                  drop
);

    localparam int EW = W + FLAG_W;

    logic [FLAG_W-1:0] in_flags;
    logic [EW-1:0]     wr_entry;
    logic [EW-1:0]     rd_entry;
    logic              full;
    logic              empty;

    assign in_flags = {bus.in_inv, bus.in_ov, bus.in_un, bus.in_inexact};
    assign wr_entry = {in_flags, bus.in_data};

    fp_sync_fifo #(
        .DW    (EW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.in_valid),
        .pop_i   (bus.out_ready),
        .wdata_i (wr_entry),
        .rdata_o (rd_entry),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_data  = rd_entry[W-1:0];
    assign bus.out_flags = rd_entry[EW-1:W];

`ifdef FP_STICKY_FLAGS_EN
    logic [FLAG_W-1:0] sticky_q, sticky_d;
    logic              drop_q, drop_d;
    logic              push_acc;
    logic              push_ref;

    assign push_acc = bus.in_valid && !full;
    assign push_ref = bus.in_valid && full;

    // Clear only wipes the old value: a same-cycle push still lands, and a refused push still sets drop.
    always_comb begin
        sticky_d = flags_clr ? '0 : sticky_q;
        drop_d   = flags_clr ? 1'b0 : drop_q;
        if (push_acc) begin
            sticky_d = sticky_d | in_flags;
        end
        if (push_ref) begin
            drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
            drop_q   <= drop_d;
        end
    end

    assign sticky_flags = sticky_q;
    assign drop         = drop_q;
`else
    logic unused_flags_clr;

    assign unused_flags_clr = flags_clr;
    assign sticky_flags     = '0;
    assign drop             = 1'b0;
`endif

endmodule

// File: tb/tb_fp_result_collector.sv
// Directed bench for fp_result_collector: FIFO ordering, full/empty corners, wrap, sticky flags, reset.
module tb_fp_result_collector;
    import fp_pkg::*;

`ifdef FP_STICKY_FLAGS_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic [2:0]        count;
    logic              flags_clr;
    logic [FLAG_W-1:0] sticky_flags;
    logic              drop;

    int checks;
    int errors;

    fp_result_collector_if #(.W(32)) bus ();

    fp_result_collector #(
        .W     (32),
        .DEPTH (4),
        .AW    (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .count        (count),
        .flags_clr    (flags_clr),
        .sticky_flags (sticky_flags),
        .drop         (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [31:0] data, input logic [3:0] fl);
        bus.in_valid   = vld;
        bus.in_data    = data;
        bus.in_inv     = fl[3];
        bus.in_ov      = fl[2];
        bus.in_un      = fl[1];
        bus.in_inexact = fl[0];
    endtask

    logic [31:0] fill_vals [4];

    initial begin
        checks = 0;
        errors = 0;
        fill_vals[0] = 32'h3F80_0000;
        fill_vals[1] = 32'h4000_0000;
        fill_vals[2] = 32'h4040_0000;
        fill_vals[3] = 32'h4080_0000;

        rst = 1'b1;
        flags_clr = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 32'h0, 4'h0);
        tick();
        tick();
        rst = 1'b0;

        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_flags", 64'(bus.out_flags), 64'd0);
        check("rst_sticky", 64'(sticky_flags), 64'd0);
        check("rst_drop", 64'(drop), 64'd0);

        // Basic push/pop
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h40C0_0000, 4'h0);
        tick();
        drive(1'b0, 32'h0, 4'h0);
        check("basic_vld", 64'(bus.out_valid), 64'd1);
        check("basic_data", 64'(bus.out_data), 64'h40C0_0000);
        check("basic_flags", 64'(bus.out_flags), 64'd0);
        check("basic_count1", 64'(count), 64'd1);
        tick();
        check("basic_count0", 64'(count), 64'd0);
        check("basic_empty", 64'(bus.out_valid), 64'd0);

        // Fill and hold, then overflow
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, fill_vals[i], 4'h0);
            tick();
        end
        drive(1'b0, 32'h0, 4'h0);
        check("fill_count", 64'(count), 64'd4);
        check("fill_in_ready", 64'(bus.in_ready), 64'd0);
        check("fill_head", 64'(bus.out_data), 64'h3F80_0000);
        check("fill_drop_before", 64'(drop), 64'd0);
        drive(1'b1, 32'h40A0_0000, 4'h0);
        tick();
        drive(1'b0, 32'h0, 4'h0);
        check("ovf_count", 64'(count), 64'd4);
        check("ovf_drop", 64'(drop), 64'(STICKY));
        check("ovf_head_stable", 64'(bus.out_data), 64'h3F80_0000);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_vld%0d", i), 64'(bus.out_valid), 64'd1);
            check($sformatf("drain_data%0d", i), 64'(bus.out_data), 64'(fill_vals[i]));
            tick();
        end
        check("drain_count", 64'(count), 64'd0);
        check("drain_empty", 64'(bus.out_valid), 64'd0);

        // Full with simultaneous push and pop
        bus.out_ready = 1'b0;
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        check("clr_drop", 64'(drop), 64'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(i + 1), 4'h0);
            tick();
        end
        drive(1'b1, 32'd5, 4'h0);
        bus.out_ready = 1'b1;
        tick();
        drive(1'b0, 32'h0, 4'h0);
        bus.out_ready = 1'b0;
        check("fsim_count", 64'(count), 64'd3);
        check("fsim_drop", 64'(drop), 64'(STICKY));
        check("fsim_head", 64'(bus.out_data), 64'd2);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("fsim_data%0d", i), 64'(bus.out_data), 64'(i + 2));
            tick();
        end
        check("fsim_empty", 64'(bus.out_valid), 64'd0);

        // Wrap: back-to-back push/pop pairs
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 4'h0);
            tick();
            check($sformatf("wrap_vld%0d", i), 64'(bus.out_valid), 64'd1);
            check($sformatf("wrap_data%0d", i), 64'(bus.out_data), 64'h100 + 64'(i));
            check($sformatf("wrap_count%0d", i), 64'(count), 64'd1);
        end
        drive(1'b0, 32'h0, 4'h0);
        tick();
        check("wrap_count_end", 64'(count), 64'd0);

        // Sticky accumulation and clear with same-cycle push
        bus.out_ready = 1'b0;
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        check("sticky_clr0", 64'(sticky_flags), 64'd0);
        drive(1'b1, FP_INFP, 4'b0100);
        tick();
        drive(1'b1, FP_ONEP, 4'b0001);
        tick();
        drive(1'b0, 32'h0, 4'h0);
        check("sticky_ov_inx", 64'(sticky_flags), STICKY ? 64'b0101 : 64'd0);
        check("sticky_head_flags", 64'(bus.out_flags), 64'b0100);
        check("sticky_head_data", 64'(bus.out_data), 64'(FP_INFP));
        flags_clr = 1'b1;
        drive(1'b1, FP_NANQ, 4'b1000);
        tick();
        flags_clr = 1'b0;
        drive(1'b0, 32'h0, 4'h0);
        check("sticky_clr_push", 64'(sticky_flags), STICKY ? 64'b1000 : 64'd0);
        check("sticky_count", 64'(count), 64'd3);

        // Reset with entries queued
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_count", 64'(count), 64'd0);
        check("mrst_vld", 64'(bus.out_valid), 64'd0);
        check("mrst_sticky", 64'(sticky_flags), 64'd0);
        check("mrst_drop", 64'(drop), 64'd0);
        check("mrst_data", 64'(bus.out_data), 64'd0);
        check("mrst_in_ready", 64'(bus.in_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
